// File: rtl/clk_div_ctrl_if.sv
// Control and status bundle of the slow-clock divider.
// Carries the mode/halt/step/divisor controls in and the divided clock, strobes and debug state out.
interface clk_div_ctrl_if #(
   parameter int unsigned CNT_W = 25
);
   logic [1:0]       mode;
   logic             halt;
   logic             step_req;
   logic             div_we;
   logic [CNT_W-1:0] div_in;
   logic             slow_clk;
   logic             rise_pulse;
   logic             fall_pulse;
   logic             parked;
   logic             busy;
   logic [1:0]       step_state;

   // Write semantics: div_we is a one-cycle valid with an implicit, always-asserted ready;
   // div_in is captured on every rising clk edge where div_we=1, and no back-pressure exists.
   modport master (
      output mode, halt, step_req, div_we, div_in,
      input  slow_clk, rise_pulse, fall_pulse, parked, busy, step_state
   );
   modport slave (
      input  mode, halt, step_req, div_we, div_in,
      output slow_clk, rise_pulse, fall_pulse, parked, busy, step_state
   );
endinterface

// File: rtl/clk_div_ctrl.sv
// Slow-clock generator with four modes (fast/slow/user/single-step), halt parking,
// a runtime-writable user divisor and one-cycle rise/fall strobes in the clk domain.
module clk_div_ctrl #(
   parameter int unsigned CNT_W         = 25,
   parameter int unsigned DIV_FAST      = 0,
   parameter int unsigned DIV_SLOW      = 25000000,
   parameter int unsigned DIV_STEP      = 2500,
   parameter int unsigned DIV_USER_INIT = 250000
) (
   input logic           clk,
   input logic           reset,
   clk_div_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      FINISH = 2'd0,
      IDLE   = 2'd1,
      LOW    = 2'd2,
      HIGH   = 2'd3
   } state_t;

   localparam logic [1:0] M_FAST = 2'b00;
   localparam logic [1:0] M_SLOW = 2'b01;
   localparam logic [1:0] M_USER = 2'b10;
   localparam logic [1:0] M_STEP = 2'b11;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] user_div_q, user_div_d;
   logic [CNT_W-1:0] adiv;
   logic [1:0]       mode_q;
   logic             slow_q, slow_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             parked_q, parked_d;
   logic             busy_q, busy_d;
   logic [1:0]       sync_q;
   logic             step_dly_q;
   logic             step_edge;
   logic             at_div;

   // Two-flop synchroniser on the asynchronous button, then a rising-edge detect.
   assign step_edge = sync_q[1] & ~step_dly_q;

   always_comb begin
      adiv = CNT_W'(DIV_STEP);
      case (mode_q)
         M_FAST:  adiv = CNT_W'(DIV_FAST);
         M_SLOW:  adiv = CNT_W'(DIV_SLOW);
         M_USER:  adiv = user_div_q;
         default: adiv = CNT_W'(DIV_STEP);
      endcase
   end

   // >= rather than == so a divisor lowered below the running count toggles at once.
   assign at_div = (count_q >= adiv);

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      slow_d     = slow_q;
      rise_d     = 1'b0;
      fall_d     = 1'b0;
      parked_d   = 1'b0;
      busy_d     = busy_q;
      user_div_d = bus.div_we ? bus.div_in : user_div_q;

      if (bus.mode != mode_q) begin
         // Dead edge: restart counting, keep the clock level, no strobe.
         count_d = '0;
         busy_d  = 1'b0;
         if (bus.mode == M_STEP) begin
            state_d  = slow_q ? IDLE : FINISH;
            parked_d = slow_q;
         end else begin
            state_d  = IDLE;
            parked_d = bus.halt & slow_q;
         end
      end else if (mode_q != M_STEP) begin
         busy_d = 1'b0;
         if (bus.halt && slow_q) begin
            parked_d = 1'b1;
         end else if (at_div) begin
            count_d  = '0;
            slow_d   = ~slow_q;
            rise_d   = ~slow_q;
            fall_d   = slow_q;
            parked_d = bus.halt & ~slow_q;
         end else begin
            count_d = count_q + CNT_W'(1);
         end
      end else begin
         case (state_q)
            FINISH: begin
               if (at_div) begin
                  count_d  = '0;
                  slow_d   = 1'b1;
                  rise_d   = 1'b1;
                  parked_d = 1'b1;
                  state_d  = IDLE;
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end
            IDLE: begin
               count_d  = '0;
               parked_d = 1'b1;
               if (step_edge) begin
                  slow_d   = 1'b0;
                  fall_d   = 1'b1;
                  busy_d   = 1'b1;
                  parked_d = 1'b0;
                  state_d  = LOW;
               end
            end
            LOW: begin
               if (at_div) begin
                  count_d = '0;
                  slow_d  = 1'b1;
                  rise_d  = 1'b1;
                  state_d = HIGH;
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end
            HIGH: begin
               if (at_div) begin
                  count_d  = '0;
                  busy_d   = 1'b0;
                  parked_d = 1'b1;
                  state_d  = IDLE;
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= FINISH;
         count_q    <= '0;
         user_div_q <= CNT_W'(DIV_USER_INIT);
         mode_q     <= M_FAST;
         slow_q     <= 1'b0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         parked_q   <= 1'b0;
         busy_q     <= 1'b0;
         sync_q     <= 2'b00;
         step_dly_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         user_div_q <= user_div_d;
         mode_q     <= bus.mode;
         slow_q     <= slow_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         parked_q   <= parked_d;
         busy_q     <= busy_d;
         sync_q     <= {sync_q[0], bus.step_req};
         step_dly_q <= sync_q[1];
      end
   end

   assign bus.slow_clk   = slow_q;
   assign bus.rise_pulse = rise_q;
   assign bus.fall_pulse = fall_q;
   assign bus.parked     = parked_q;
   assign bus.busy       = busy_q;
   assign bus.step_state = state_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed phases from the test plan plus a random phase,
// every cycle compared against a behavioural model of the divider.
module tb_clk_div_ctrl;

   localparam int CNT_W         = 8;
   localparam int DIV_FAST      = 0;
   localparam int DIV_SLOW      = 3;
   localparam int DIV_STEP      = 1;
   localparam int DIV_USER_INIT = 2;

   logic clk = 1'b0;
   logic reset;

   clk_div_ctrl_if #(.CNT_W(CNT_W)) bus ();

   clk_div_ctrl #(
      .CNT_W         (CNT_W),
      .DIV_FAST      (DIV_FAST),
      .DIV_SLOW      (DIV_SLOW),
      .DIV_STEP      (DIV_STEP),
      .DIV_USER_INIT (DIV_USER_INIT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Behavioural model: clock level, strobes, and cycles left in the current step/finish phase.
   int m_mode_q, m_user, m_elapsed, m_step_left, m_finish_left;
   bit m_level, m_rise, m_fall, m_parked, m_busy;
   bit req_hist [3];

   task automatic check(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode_q = 0; m_user = DIV_USER_INIT; m_elapsed = 0;
      m_step_left = 0; m_finish_left = 0;
      m_level = 0; m_rise = 0; m_fall = 0; m_parked = 0; m_busy = 0;
      for (int i = 0; i < 3; i++) req_hist[i] = 0;
   endtask

   task automatic model_edge();
      int  adiv;
      int  half;
      bit  edge_seen;
      half      = DIV_STEP + 1;
      edge_seen = req_hist[1] && !req_hist[2];
      m_rise = 0;
      m_fall = 0;
      if (int'(bus.mode) != m_mode_q) begin
         m_elapsed   = 0;
         m_busy      = 0;
         m_step_left = 0;
         if (bus.mode == 2'b11) begin
            m_finish_left = m_level ? 0 : half;
            m_parked      = m_level;
         end else begin
            m_finish_left = 0;
            m_parked      = bus.halt && m_level;
         end
      end else if (m_mode_q != 3) begin
         adiv = (m_mode_q == 0) ? DIV_FAST : (m_mode_q == 1) ? DIV_SLOW : m_user;
         if (bus.halt && m_level) begin
            m_parked = 1;
         end else if (m_elapsed >= adiv) begin
            m_elapsed = 0;
            m_level   = !m_level;
            m_rise    = m_level;
            m_fall    = !m_level;
            m_parked  = bus.halt && m_level;
         end else begin
            m_elapsed++;
            m_parked = 0;
         end
      end else begin
         m_parked = 0;
         if (m_finish_left > 0) begin
            m_finish_left--;
            if (m_finish_left == 0) begin
               m_level = 1; m_rise = 1; m_parked = 1;
            end
         end else if (m_step_left > 0) begin
            m_step_left--;
            if (m_step_left == half) begin
               m_level = 1; m_rise = 1;
            end
            if (m_step_left == 0) begin
               m_busy = 0; m_parked = 1;
            end
         end else begin
            m_parked = 1;
            if (edge_seen) begin
               m_level = 0; m_fall = 1; m_busy = 1; m_parked = 0;
               m_step_left = 2 * half;
            end
         end
      end
      if (bus.div_we) m_user = int'(bus.div_in);
      m_mode_q   = int'(bus.mode);
      req_hist[2] = req_hist[1];
      req_hist[1] = req_hist[0];
      req_hist[0] = bus.step_req;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".slow_clk"}, bus.slow_clk, m_level);
      check({tag, ".rise"},     bus.rise_pulse, m_rise);
      check({tag, ".fall"},     bus.fall_pulse, m_fall);
      check({tag, ".parked"},   bus.parked, m_parked);
      check({tag, ".busy"},     bus.busy, m_busy);
      check({tag, ".one_strobe"}, bus.rise_pulse & bus.fall_pulse, 1'b0);
   endtask

   task automatic tick(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   // sel: 0 rise, 1 fall, otherwise either strobe; returns clk edges taken (limit on timeout).
   task automatic cycles_to(input string tag, input int sel, input int limit, output int n);
      bit hit;
      n   = 0;
      hit = 0;
      while (!hit && n < limit) begin
         tick(tag);
         n++;
         case (sel)
            0:       hit = bus.rise_pulse;
            1:       hit = bus.fall_pulse;
            default: hit = bus.rise_pulse | bus.fall_pulse;
         endcase
      end
   endtask

   task automatic step_window(input string tag, input bit glitch, output int busy_n,
                              output int falls, output int rises);
      busy_n = 0; falls = 0; rises = 0;
      bus.step_req = 1'b1;
      for (int i = 1; i <= 50; i++) begin
         tick(tag);
         busy_n += int'(bus.busy);
         falls  += int'(bus.fall_pulse);
         rises  += int'(bus.rise_pulse);
         if (glitch && i == 2) bus.step_req = 1'b0;
         if (glitch && i == 3) bus.step_req = 1'b1;
         if (i == 10) bus.step_req = 1'b0;
      end
   endtask

   initial begin
      int n, cnt, busy_n, falls, rises;

      reset        = 1'b0;
      bus.mode     = 2'b01;
      bus.halt     = 1'b0;
      bus.step_req = 1'b0;
      bus.div_we   = 1'b0;
      bus.div_in   = '0;
      model_reset();
      #12;
      check("reset.slow_clk", bus.slow_clk, 1'b0);
      check("reset.rise",     bus.rise_pulse, 1'b0);
      check("reset.fall",     bus.fall_pulse, 1'b0);
      check("reset.parked",   bus.parked, 1'b0);
      check("reset.busy",     bus.busy, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // SLOW: the registered mode starts at FAST, so one dead edge precedes the 4-clk half.
      cycles_to("slow", 0, 20, n);
      check_int("slow.first_rise", n, 1 + DIV_SLOW + 1);
      cycles_to("slow", 1, 20, n);
      check_int("slow.high_half", n, DIV_SLOW + 1);
      cycles_to("slow", 0, 20, n);
      check_int("slow.low_half", n, DIV_SLOW + 1);

      bus.mode = 2'b00;
      tick("fast.dead");
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick("fast");
         cnt += int'(bus.rise_pulse) + int'(bus.fall_pulse);
      end
      check_int("fast.strobes", cnt, 6);

      bus.mode = 2'b10;
      tick("user.dead");
      check("user.dead_no_strobe", bus.rise_pulse | bus.fall_pulse, 1'b0);
      cycles_to("user", 2, 20, n);
      check_int("user.first_half", n, DIV_USER_INIT + 1);
      cycles_to("user", 2, 20, n);
      check_int("user.half", n, DIV_USER_INIT + 1);

      // Halt raised while low: rise on schedule, then park high.
      bus.mode = 2'b01;
      tick("halt.dead");
      cycles_to("halt", 1, 20, n);
      bus.halt = 1'b1;
      cycles_to("halt", 0, 20, n);
      check_int("halt.rise_on_time", n, DIV_SLOW + 1);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick("halt.parked");
         cnt += int'(bus.parked & bus.slow_clk);
      end
      check_int("halt.parked_cycles", cnt, 20);
      bus.halt = 1'b0;
      cycles_to("halt.resume", 1, 20, n);
      check_int("halt.resume_fall", n, DIV_SLOW + 1);

      bus.mode = 2'b10;
      tick("wr.dead");
      tick("wr.count1");
      bus.div_we = 1'b1;
      bus.div_in = 8'd0;
      tick("wr.zero");
      bus.div_we = 1'b0;
      cycles_to("wr.lowered", 2, 20, n);
      check_int("wr.lowered_toggle", n, 1);
      bus.div_we = 1'b1;
      bus.div_in = 8'd5;
      tick("wr.five");
      check("wr.old_value_used", bus.rise_pulse | bus.fall_pulse, 1'b1);
      bus.div_we = 1'b0;
      cycles_to("wr.six", 2, 20, n);
      check_int("wr.half_six", n, 6);
      cycles_to("wr.six", 2, 20, n);
      check_int("wr.half_six_again", n, 6);

      bus.mode = 2'b11;
      tick("step.dead");
      for (int i = 0; i < 6; i++) tick("step.settle");
      check("step.idle_parked", bus.parked & bus.slow_clk, 1'b1);
      step_window("step.a", 1'b0, busy_n, falls, rises);
      check_int("step.a.busy", busy_n, 2 * (DIV_STEP + 1));
      check_int("step.a.falls", falls, 1);
      check_int("step.a.rises", rises, 1);
      step_window("step.b", 1'b1, busy_n, falls, rises);
      check_int("step.b.busy", busy_n, 2 * (DIV_STEP + 1));
      check_int("step.b.falls", falls, 1);
      check_int("step.b.rises", rises, 1);

      // Asynchronous reset in the middle of a step.
      bus.step_req = 1'b1;
      for (int i = 0; i < 4; i++) tick("rst.pre");
      check("rst.pre_busy", bus.busy, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check("rst.slow_clk", bus.slow_clk, 1'b0);
      check("rst.rise",     bus.rise_pulse, 1'b0);
      check("rst.fall",     bus.fall_pulse, 1'b0);
      check("rst.parked",   bus.parked, 1'b0);
      check("rst.busy",     bus.busy, 1'b0);
      bus.step_req = 1'b0;
      bus.mode     = 2'b10;
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick("rst.dead");
      cycles_to("rst.user", 2, 20, n);
      check_int("rst.user_div_restored", n, DIV_USER_INIT + 1);
      cycles_to("rst.user", 2, 20, n);
      check_int("rst.user_half", n, DIV_USER_INIT + 1);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) bus.mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) bus.halt = ~bus.halt;
         bus.div_we = ($urandom_range(0, 9) == 0);
         bus.div_in = 8'($urandom_range(0, 6));
         if ($urandom_range(0, 5) == 0) bus.step_req = ~bus.step_req;
         tick("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
